// File: rtl/bias_result_serializer_pkg.sv
// Shared accelerator constants and FSM state type for the biased-result serializer.
package bias_result_serializer_pkg;

    localparam int unsigned NUM    = 25;
    localparam int unsigned AB_BW  = 25;
    localparam int unsigned OUT_BW = 8;
    localparam int unsigned IDX_BW = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/requant_clamp.sv
// Round-half-up arithmetic right shift of one signed biased result, then ReLU and
// saturation to an unsigned OUT_BW-bit value.
module requant_clamp #(
    parameter int unsigned AB_BW  = bias_result_serializer_pkg::AB_BW,
    parameter int unsigned OUT_BW = bias_result_serializer_pkg::OUT_BW,
    parameter int unsigned SH_BW  = bias_result_serializer_pkg::IDX_BW
) (
    input  logic [AB_BW-1:0]  i_x,
    input  logic [SH_BW-1:0]  i_shift,
    output logic [OUT_BW-1:0] o_y
);

    logic signed [AB_BW:0] w_round;
    logic signed [AB_BW:0] w_sum;
    logic signed [AB_BW:0] w_shr;

    always_comb begin
        w_round = '0;
        if (i_shift != '0) begin
            w_round = (AB_BW+1)'(1) << (i_shift - SH_BW'(1));
        end
        // One extra bit of headroom so adding the rounding constant cannot overflow.
        w_sum = $signed({i_x[AB_BW-1], i_x}) + w_round;
        w_shr = w_sum >>> i_shift;

        if (w_shr[AB_BW]) begin
            o_y = '0;
        end else if (|w_shr[AB_BW-1:OUT_BW]) begin
            o_y = '1;
        end else begin
            o_y = w_shr[OUT_BW-1:0];
        end
    end

endmodule

// File: rtl/bias_result_serializer.sv
// Captures NUM biased results in parallel and streams them out one quantized element per
// ready/valid handshake, in index order.
module bias_result_serializer #(
    parameter int unsigned NUM    = bias_result_serializer_pkg::NUM,
    parameter int unsigned AB_BW  = bias_result_serializer_pkg::AB_BW,
    parameter int unsigned OUT_BW = bias_result_serializer_pkg::OUT_BW
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         i_valid,
    output logic                                         o_ready,
    input  logic [NUM*AB_BW-1:0]                         i_acc_bias,
    input  logic [bias_result_serializer_pkg::IDX_BW-1:0] i_shift,
    output logic                                         o_valid,
    input  logic                                         i_ready,
    output logic [OUT_BW-1:0]                            o_data,
    output logic [bias_result_serializer_pkg::IDX_BW-1:0] o_idx,
    output logic                                         o_last
);

    import bias_result_serializer_pkg::*;

    localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(NUM - 1);

    state_t            r_state;
    logic              r_ready;
    logic              r_valid;
    logic              r_last;
    logic [IDX_BW-1:0] r_idx;
    logic [IDX_BW-1:0] r_shift;
    logic [AB_BW-1:0]  r_data [NUM];

    logic              w_capture;
    logic [IDX_BW-1:0] w_idx_next;
    logic [AB_BW-1:0]  w_sel;
    logic [OUT_BW-1:0] w_q;

    assign w_capture  = (r_state == IDLE) && i_valid;
    assign w_idx_next = r_idx + IDX_BW'(1);
    assign w_sel      = r_data[r_idx];

    // Capture registers carry no reset; they are only read after a capture fills them.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int k = 0; k < NUM; k++) begin
                r_data[k] <= i_acc_bias[k*AB_BW +: AB_BW];
            end
            r_shift <= i_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_state <= SEND;
                        r_ready <= 1'b0;
                        r_valid <= 1'b1;
                        r_idx   <= '0;
                        r_last  <= (NUM == 1);
                    end
                end
                SEND: begin
                    if (i_ready) begin
                        if (r_idx == LAST_IDX) begin
                            r_state <= IDLE;
                            r_ready <= 1'b1;
                            r_valid <= 1'b0;
                            r_idx   <= '0;
                            r_last  <= 1'b0;
                        end else begin
                            r_idx  <= w_idx_next;
                            r_last <= (w_idx_next == LAST_IDX);
                        end
                    end
                end
            endcase
        end
    end

    requant_clamp #(
        .AB_BW (AB_BW),
        .OUT_BW(OUT_BW),
        .SH_BW (IDX_BW)
    ) u_requant_clamp (
        .i_x    (w_sel),
        .i_shift(r_shift),
        .o_y    (w_q)
    );

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_idx   = r_idx;
    assign o_last  = r_last;
    // Masked outside SEND so stale or unset capture contents never reach the port.
    assign o_data  = r_valid ? w_q : '0;

endmodule

// File: tb/tb_bias_result_serializer.sv
// Randomized bench for bias_result_serializer against an arithmetic quantization model.
module tb_bias_result_serializer;

    localparam int NUM    = 25;
    localparam int AB_BW  = 25;
    localparam int OUT_BW = 8;

    logic                   clk;
    logic                   rst;
    logic                   i_valid;
    logic                   o_ready;
    logic [NUM*AB_BW-1:0]   i_acc_bias;
    logic [4:0]             i_shift;
    logic                   o_valid;
    logic                   i_ready;
    logic [OUT_BW-1:0]      o_data;
    logic [4:0]             o_idx;
    logic                   o_last;

    int                     n_checks;
    int                     n_fail;
    int                     elems [NUM];
    int                     cur_shift;
    logic [NUM*AB_BW-1:0]   cap_bus;

    bias_result_serializer #(
        .NUM   (NUM),
        .AB_BW (AB_BW),
        .OUT_BW(OUT_BW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_acc_bias(i_acc_bias),
        .i_shift   (i_shift),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_idx     (o_idx),
        .o_last    (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: round-half-up divide by 2^sh (floor via arithmetic shift), then clamp.
    function automatic int quant(input int x, input int sh);
        longint v;
        v = x;
        if (sh != 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
        if (v < 0) return 0;
        if (v > (longint'(1) << OUT_BW) - 1) return (1 << OUT_BW) - 1;
        return int'(v);
    endfunction

    function automatic int rand_elem();
        logic [24:0] t;
        int          m;
        m = int'($urandom_range(0, 2));
        t = 25'($urandom);
        if (m == 0) return int'({{7{t[24]}}, t});
        if (m == 1) return int'($urandom_range(0, 70000));
        return -int'($urandom_range(0, 5000));
    endfunction

    task automatic capture(input int sh);
        int w;
        w = 0;
        while (!o_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_eq("ready_before_capture", o_ready, 1);
        for (int k = 0; k < NUM; k++) cap_bus[k*AB_BW +: AB_BW] = elems[k][AB_BW-1:0];
        cur_shift  = sh;
        i_acc_bias = cap_bus;
        i_shift    = 5'(sh);
        i_valid    = 1'b1;
        @(negedge clk);
        i_valid    = 1'b0;
    endtask

    // mode 0: ready always high; 1: ready pattern 1,0,0,1; 2: random ready.
    task automatic drain(input int mode, input int inj_at, input int rst_at);
        int   e;
        int   c;
        bit   injected;
        logic r;
        e = 0;
        c = 0;
        injected = 1'b0;
        while (e < NUM && c < 4 * NUM + 20) begin
            i_valid = 1'b0;
            check_eq("o_valid", o_valid, 1);
            check_eq("o_ready_busy", o_ready, 0);
            check_eq("o_idx", o_idx, e);
            check_eq("o_data", o_data, quant(elems[e], cur_shift));
            check_eq("o_last", o_last, (e == NUM - 1));
            if (e == rst_at) begin
                rst     = 1'b1;
                i_ready = 1'b1;
                @(negedge clk);
                rst     = 1'b0;
                check_eq("rst_valid", o_valid, 0);
                check_eq("rst_idx", o_idx, 0);
                check_eq("rst_ready", o_ready, 1);
                check_eq("rst_data", o_data, 0);
                check_eq("rst_last", o_last, 0);
                @(negedge clk);
                check_eq("rst_abandon_valid", o_valid, 0);
                return;
            end
            if (e == inj_at && !injected) begin
                injected   = 1'b1;
                i_valid    = 1'b1;
                i_acc_bias = ~cap_bus;
                i_shift    = 5'd3;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = ((c % 4) == 0) || ((c % 4) == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            i_ready = r;
            if (r) e++;
            c++;
            @(negedge clk);
        end
        i_valid = 1'b0;
        i_ready = 1'b0;
        check_eq("transfer_count", e, NUM);
        check_eq("done_valid", o_valid, 0);
        check_eq("done_ready", o_ready, 1);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        i_valid    = 1'b0;
        i_ready    = 1'b0;
        i_acc_bias = '0;
        i_shift    = '0;
        cap_bus    = '0;
        cur_shift  = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("reset_ready", o_ready, 1);
        check_eq("reset_valid", o_valid, 0);
        check_eq("reset_idx", o_idx, 0);
        check_eq("reset_data", o_data, 0);
        check_eq("reset_last", o_last, 0);

        // Ramp k*256 >> 8 gives k, back-to-back outputs.
        for (int k = 0; k < NUM; k++) elems[k] = k * 256;
        capture(8);
        drain(0, -1, -1);

        // Shift 0: ReLU and saturation extremes.
        for (int k = 0; k < NUM; k++) elems[k] = rand_elem();
        elems[0] = -1000;
        elems[1] = 32'h00FF_FFFF;
        capture(0);
        drain(0, -1, -1);

        // Round-half-up boundary.
        for (int k = 0; k < NUM; k++) elems[k] = rand_elem();
        elems[0] = 383;
        elems[1] = 384;
        capture(8);
        drain(0, -1, -1);

        // Stall pattern 1,0,0,1.
        for (int k = 0; k < NUM; k++) elems[k] = rand_elem();
        capture(int'($urandom_range(0, 24)));
        drain(1, -1, -1);

        // New capture attempted mid-stream must be ignored.
        for (int k = 0; k < NUM; k++) elems[k] = rand_elem();
        capture(int'($urandom_range(1, 24)));
        drain(0, 10, -1);

        // Reset mid-stream, then a fresh capture.
        for (int k = 0; k < NUM; k++) elems[k] = rand_elem();
        capture(int'($urandom_range(0, 24)));
        drain(0, -1, 12);

        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < NUM; k++) elems[k] = rand_elem();
            capture(int'($urandom_range(0, 24)));
            drain(2, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bias_result_serializer.md
BIAS_RESULT_SERIALIZER -- requirements
Module: bias_result_serializer

Interface
REQ-001 SHALL have parameter NUM, default 25: number of parallel biased results per capture.
REQ-002 SHALL have parameter AB_BW, default 25: width of each signed two's-complement biased result.
REQ-003 SHALL have parameter OUT_BW, default 8: width of each unsigned quantized output.
REQ-004 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port i_valid, input, 1: i_acc_bias and i_shift are valid this cycle.
REQ-007 SHALL have port o_ready, output, 1: block can accept a capture.
REQ-008 SHALL have port i_acc_bias, input, NUM*AB_BW: packed results; element k at [k*AB_BW +: AB_BW].
REQ-009 SHALL have port i_shift, input, 5: requantization right-shift amount, 0..24.
REQ-010 SHALL have port o_valid, output, 1: o_data, o_idx and o_last are valid.
REQ-011 SHALL have port i_ready, input, 1: downstream accepts the current output.
REQ-012 SHALL have port o_data, output, OUT_BW: quantized element.
REQ-013 SHALL have port o_idx, output, 5: element index of o_data, 0..NUM-1.
REQ-014 SHALL have port o_last, output, 1: high with o_valid when o_idx equals NUM-1.

Function
REQ-015 SHALL implement exactly two FSM states: IDLE and SEND.
REQ-016 SHALL drive o_ready high only in IDLE, and o_valid high only in SEND.
REQ-017 SHALL, on i_valid and o_ready, capture all NUM elements and i_shift into internal registers, clear the index, and enter SEND on the next cycle.
REQ-018 SHALL present element 0 with o_valid high in the cycle after the capture (latency 1).
REQ-019 SHALL transfer one element only on cycles with o_valid and i_ready both high, incrementing o_idx by 1.
REQ-020 SHALL hold o_data, o_idx and o_last stable while o_valid is high and i_ready is low.
REQ-021 SHALL, when the transfer with o_idx equal to NUM-1 completes, return to IDLE and assert o_ready in the next cycle; no back-to-back captures occur.
REQ-022 SHALL ignore i_valid while in SEND and leave the captured contents unchanged.
REQ-023 SHALL quantize each element x as follows: for i_shift of 0, y equals x; otherwise y equals (x + 2^(i_shift-1)) arithmetically shifted right by i_shift, with the sum computed in AB_BW+1 bits so it cannot overflow.
REQ-024 SHALL clamp y to the range 0..2^OUT_BW-1: negative values become 0 (ReLU) and values above the range become the maximum.
REQ-025 SHALL never wrap o_idx past NUM-1.

Reset
REQ-026 SHALL, while rst is high at a clock edge, enter IDLE and set o_valid=0, o_data=0, o_idx=0, o_last=0.
REQ-027 SHALL assert o_ready in the first cycle after rst deasserts.
REQ-028 SHALL, on reset in mid-SEND, abandon the pending elements; no further element of that capture is emitted.
REQ-029 SHALL give the capture registers no reset requirement; their contents are don't-care until the first capture.

Structure
REQ-030 SHALL place NUM, AB_BW, OUT_BW, the 5-bit index/shift width and the FSM state enum in the shared accelerator package.
REQ-031 SHALL implement quantization in one combinational sub-module named requant_clamp, instantiated once on the selected element.
REQ-032 SHALL select the element with an index-driven mux over the capture registers, not with a shift register.

Verification
REQ-033 SHALL test: element k = k*256, i_shift 8, i_ready held 1 -> 25 outputs on consecutive cycles with o_data = k, o_last only at o_idx 24, o_ready high one cycle later.
REQ-034 SHALL test: element 0 = -1000 and element 1 = 0x0FFFFFF (max positive), i_shift 0 -> o_data 0, then 255.
REQ-035 SHALL test: element 0 = 383, i_shift 8 -> o_data 1; element 1 = 384 -> o_data 2 (round-half-up).
REQ-036 SHALL test: i_ready toggled 1,0,0,1 repeatedly -> o_data and o_idx held during stalls, no skipped or duplicated index, exactly 25 transfers.
REQ-037 SHALL test: i_valid pulsed with new data at o_idx 10 -> ignored, outputs 10..24 from the original capture.
REQ-038 SHALL test: rst asserted at o_idx 12 -> next cycle o_valid 0, o_idx 0, o_ready 1; a new capture restarts cleanly at index 0.
